// File: rtl/red_pitaya_fads_sort_scheduler.sv
// Time-of-flight scheduler: queues "sort" droplets with a due timestamp and
// fires a sort pulse when the oldest entry falls due.
module red_pitaya_fads_sort_scheduler #(
  parameter int DEPTH = 8,
  parameter int TSW   = 32,
  parameter int CW    = 32
) (
  input  logic                     adc_clk_i,
  input  logic                     adc_rstn_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic [TSW-1:0]           delay_i,
  input  logic [TSW-1:0]           pulse_len_i,
  input  logic                     det_valid_i,
  input  logic                     det_sort_i,
  output logic                     sort_trig_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic [CW-1:0]            sorted_cnt_o,
  output logic [CW-1:0]            drop_cnt_o,
  output logic [CW-1:0]            retrig_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t         state_q, state_d;
  logic [TSW-1:0] cnt_q, cnt_d;
  logic [TSW-1:0] ts_q;
  logic [TSW-1:0] mem [DEPTH];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [AW:0]    count_q;

  logic [TSW-1:0] delay_eff, len_eff, head_due, late;
  logic           due, pop, push_req, push, full, drop;

  assign delay_eff = (delay_i == '0) ? TSW'(1) : delay_i;
  assign len_eff   = (pulse_len_i == '0) ? TSW'(1) : pulse_len_i;

  // Signed distance past the due time; wrap-safe while delays stay below 2^(TSW-1).
  assign head_due  = mem[rd_ptr_q];
  assign late      = ts_q - head_due;
  assign due       = (count_q != '0) && !late[TSW-1];

  assign pop       = due && !flush_i;
  assign push_req  = det_valid_i && det_sort_i && enable_i && !flush_i;
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      ts_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ts_q <= ts_q + TSW'(1);
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (push && !pop)      count_q <= count_q + (AW+1)'(1);
        else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // NOTE: storage array has no reset; occupancy is tracked by count_q, so stale contents are never observed.
  always_ff @(posedge adc_clk_i) begin
    if (push) mem[wr_ptr_q] <= ts_q + delay_eff;
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = PULSE;
          cnt_d   = len_eff;
        end
      end
      PULSE: begin
        if (pop) begin
          cnt_d = len_eff;
        end else if (cnt_q == TSW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - TSW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sorted_cnt_o <= '0;
      drop_cnt_o   <= '0;
      retrig_cnt_o <= '0;
    end else begin
      if (pop)                      sorted_cnt_o <= sorted_cnt_o + CW'(1);
      if (pop && state_q == PULSE)  retrig_cnt_o <= retrig_cnt_o + CW'(1);
      if (drop)                     drop_cnt_o   <= drop_cnt_o + CW'(1);
    end
  end

  assign sort_trig_o = (state_q == PULSE);
  assign pending_o   = count_q;
  assign busy_o      = (state_q == PULSE) || (count_q != '0);

endmodule
